// File: rtl/wb_read_accumulator.sv
// Wishbone classic read master: reads count_i consecutive words from base_adr_i and sums them.
// Optional per-beat ack timeout is enabled by defining WB_ACC_TIMEOUT_EN.
module wb_read_accumulator #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int GRANULE        = 8,
    parameter int COUNT_WIDTH    = 4,
    parameter int SUM_WIDTH      = 40,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [ADDR_WIDTH-1:0]             base_adr_i,
    input  logic [COUNT_WIDTH-1:0]            count_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [SUM_WIDTH-1:0]              sum_o,
    output logic                              ovf_o,
    output logic                              err_o,
    output logic [ADDR_WIDTH-1:0]             adr_o,
    output logic [DATA_WIDTH-1:0]             dat_o,
    output logic [(DATA_WIDTH/GRANULE)-1:0]   sel_o,
    output logic                              we_o,
    output logic                              cyc_o,
    output logic                              stb_o,
    input  logic [DATA_WIDTH-1:0]             dat_i,
    input  logic                              ack_i,
    input  logic                              err_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
    localparam logic [ADDR_WIDTH-1:0]  ADR_ONE = ADDR_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    if (SUM_WIDTH < DATA_WIDTH) begin : g_bad_sum_width
        $error("wb_read_accumulator: SUM_WIDTH must be >= DATA_WIDTH");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_read_accumulator: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    accept_s;
    logic                    beat_s;
    logic                    abort_s;
    logic                    tmo_s;
    logic [SUM_WIDTH:0]      sum_add_s;

    logic                    busy_r;
    logic                    done_r;
    logic                    cyc_r;
    logic [SEL_WIDTH-1:0]    sel_r;
    logic [ADDR_WIDTH-1:0]   adr_r;
    logic [COUNT_WIDTH-1:0]  remain_r;
    logic [SUM_WIDTH-1:0]    sum_r;
    logic                    ovf_r;
    logic                    err_r;

    // Extra top bit catches the carry out of the accumulator.
    assign sum_add_s = {1'b0, sum_r} + (SUM_WIDTH + 1)'(dat_i);

`ifdef WB_ACC_TIMEOUT_EN
    localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_WIDTH-1:0] TMO_ONE  = TMO_WIDTH'(1);

    logic [TMO_WIDTH-1:0] tmo_cnt_r;

    // Stall counter: counts BUS cycles since the last termination, cleared outside BUS.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_r <= '0;
        end else if ((state_r != ST_BUS) || ack_i || err_i) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end
    end

    assign tmo_s = (state_r == ST_BUS) && !ack_i && !err_i && (tmo_cnt_r == TMO_LAST);
`else
    assign tmo_s = 1'b0;
`endif

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        beat_s   = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    accept_s = 1'b1;
                    state_s  = (count_i == '0) ? ST_DONE : ST_BUS;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_BUS: begin
                // Error termination wins over a simultaneous ack and discards that beat.
                if (err_i || tmo_s) begin
                    abort_s = 1'b1;
                    state_s = ST_DONE;
                end else if (ack_i) begin
                    beat_s  = 1'b1;
                    state_s = (remain_r == CNT_ONE) ? ST_DONE : ST_BUS;
                end else begin
                    state_s = ST_BUS;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and bus/status outputs, all derived from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cyc_r   <= 1'b0;
            sel_r   <= '0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_BUS);
            done_r  <= (state_s == ST_DONE);
            cyc_r   <= (state_s == ST_BUS);
            sel_r   <= (state_s == ST_BUS) ? '1 : '0;
        end
    end

    // Run datapath: address, beats remaining, sum and sticky status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adr_r    <= '0;
            remain_r <= '0;
            sum_r    <= '0;
            ovf_r    <= 1'b0;
            err_r    <= 1'b0;
        end else if (accept_s) begin
            adr_r    <= base_adr_i;
            remain_r <= count_i;
            sum_r    <= '0;
            ovf_r    <= 1'b0;
            err_r    <= 1'b0;
        end else if (beat_s) begin
            adr_r    <= adr_r + ADR_ONE;
            remain_r <= remain_r - CNT_ONE;
            sum_r    <= sum_add_s[SUM_WIDTH-1:0];
            ovf_r    <= ovf_r | sum_add_s[SUM_WIDTH];
        end else if (abort_s) begin
            err_r    <= 1'b1;
        end
    end

    assign busy_o = busy_r;
    assign done_o = done_r;
    assign sum_o  = sum_r;
    assign ovf_o  = ovf_r;
    assign err_o  = err_r;
    assign adr_o  = adr_r;
    assign dat_o  = '0;
    assign sel_o  = sel_r;
    assign we_o   = 1'b0;
    assign cyc_o  = cyc_r;
    assign stb_o  = cyc_r;

endmodule
